clock_divide_ctrl: RTL and testbench
====================================

Name: clock_divide_ctrl

Overview:
- Run/stop and reconfiguration controller for the 28-bit square-wave divider datapath.
- Owns the period counter and active divisor; produces the divided clock-enable waveform c and a one-cycle period tick.
- Accepts new divisors over a valid/ready handshake and applies them only at a period boundary, so c never shows a runt pulse.
- Sits between the top-level control/register logic and any logic clocked by the slow enable (display scan, debouncers).

Parameters:
- WIDTH, 28, counter and divisor width.
- DEFAULT_DIVISOR, 28'd14000000, active divisor after reset.
- MIN_DIVISOR, 2, smallest legal divisor; smaller requests are clamped to this value.

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level/pulse; request to begin or resume dividing.
- stop  input  1  pulse; request to halt at the end of the current period.
- cfg_valid  input  1  new divisor offered.
- cfg_divisor  input  WIDTH  offered divisor value.
- cfg_ready  output  1  controller can accept a divisor this cycle.
- c  output  1  divided waveform, registered.
- tick  output  1  one-cycle pulse on each period wrap.
- running  output  1  high in RUN or DRAIN.
- active_div  output  WIDTH  divisor currently in use.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, c=0, tick=0, running=0, active_div=DEFAULT_DIVISOR, pending flag=0, cfg_ready=1.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - counter held at 0; c<=0.
  - start -> RUN with counter=0.
  - An accepted cfg is written directly to active_div; no pending entry is created.
- RUN:
  - counter<=counter+1 each cycle.
  - When counter==active_div-1: counter<=0 and tick<=1 for the next cycle only.
  - stop -> DRAIN.
- DRAIN:
  - Counts exactly as in RUN.
  - On wrap -> IDLE (tick still pulses); c<=0 from the cycle after the wrap.
  - start without stop -> back to RUN, drain cancelled.
- start and stop in the same cycle: stop wins.
- Waveform:
  - c<=(counter < active_div>>1) is evaluated in RUN/DRAIN, so c lags counter by one cycle.
  - Odd divisors give a low phase one cycle longer than the high phase.
- Config handshake:
  - Transfer occurs when cfg_valid&&cfg_ready.
  - cfg_ready=!pending.
  - In RUN/DRAIN the value (clamped to MIN_DIVISOR) goes to a pending register.
  - On the next wrap: active_div<=pending value and pending clears, so cfg_ready returns high the cycle after the wrap.
  - If a transfer and a wrap happen in the same cycle, the new value becomes pending and applies at the following wrap.
- Counter safety: if active_div is ever at or below counter (it cannot normally be), the >= comparison wraps to 0 on the next cycle; no wrap-around past 2^WIDTH is possible.
- Mid-operation reset: immediate return to reset values on the next edge; the pending config is discarded.

Decomposition:
- Shared package clock_divide_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - WIDTH;
  - MIN_DIVISOR;
  - DEFAULT_DIVISOR.
- One natural sub-module, div_period_counter: counter, wrap detect, tick and c generation, driven by an enable and active_div from this controller's FSM and config logic.

Test Plan:
- Reset, bench DEFAULT_DIVISOR=10, start pulse -> c high 5 cycles, low 5 cycles, repeating; tick every 10 cycles; running=1.
- In IDLE, cfg_divisor=6 with cfg_valid -> cfg_ready stays 1, active_div=6 next cycle; after start, c period is 6 (3 high/3 low).
- In RUN at counter=3 with divisor 10, offer cfg_divisor=4 -> cfg_ready=0 until wrap; the first period stays 10 cycles, then period 4; a second offer during pending is held off.
- Stop at counter=2 (divisor 10) -> remains running for 8 more cycles, tick at wrap, then IDLE with c=0 and running=0; start and stop together in RUN -> DRAIN.
- cfg_divisor=0 and 1 -> active_div=2, c toggles every cycle; cfg_divisor=7 -> c high 3 cycles, low 4.
- Reset asserted mid-period with a pending config -> next cycle c=0, tick=0, running=0, active_div=DEFAULT_DIVISOR, cfg_ready=1.

Source files
------------

// File: rtl/clock_divide_pkg.sv
// Shared definitions for the run/stop divider controller and its period counter.
package clock_divide_pkg;

  localparam int                 WIDTH           = 28;
  localparam logic [WIDTH-1:0]   DEFAULT_DIVISOR = 28'd14000000;
  localparam logic [WIDTH-1:0]   MIN_DIVISOR     = 28'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/div_period_counter.sv
// Period counter for the divider: counts 0..div-1 while enabled, registers the
// square wave c (one cycle behind the count) and a one-cycle tick per wrap.
module div_period_counter #(
  parameter int WIDTH = 28
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_wrap,
  output logic             o_tick,
  output logic             o_c
);

  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_c;

  // >= rather than == so a divisor shrinking below the count still wraps.
  assign o_wrap = i_en && (r_count >= (i_div - WIDTH'(1)));

  always_ff @(posedge clock_in) begin
    if (reset || !i_en) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      r_tick  <= o_wrap;
      r_c     <= (r_count < (i_div >> 1));
      r_count <= o_wrap ? '0 : (r_count + WIDTH'(1));
    end
  end

  assign o_tick = r_tick;
  assign o_c    = r_c;

endmodule

// File: rtl/clock_divide_ctrl.sv
// Run/stop and reconfiguration controller for the square-wave divider.
// New divisors take effect only at a period boundary so c never shows a runt.
module clock_divide_ctrl
  import clock_divide_pkg::*;
#(
  parameter int               WIDTH           = clock_divide_pkg::WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = WIDTH'(clock_divide_pkg::DEFAULT_DIVISOR),
  parameter logic [WIDTH-1:0] MIN_DIVISOR     = WIDTH'(clock_divide_pkg::MIN_DIVISOR)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_divisor,
  output logic             cfg_ready,
  output logic             c,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] active_div,
  output state_e           dbg_state
);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_active_div;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pend;
  logic             w_en;
  logic             w_wrap;
  logic             w_xfer;
  logic [WIDTH-1:0] w_cfg_clamped;

  always_ff @(posedge clock_in) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // stop has priority over start; start in DRAIN cancels the drain.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start && !stop) w_next_state = ST_RUN;
      ST_RUN:   if (stop) w_next_state = ST_DRAIN;
      ST_DRAIN: begin
        if (start && !stop) w_next_state = ST_RUN;
        else if (w_wrap)    w_next_state = ST_IDLE;
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_en      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    running   = w_en;
    dbg_state = r_state;
  end

  // Handshake: a divisor transfers on any cycle where cfg_valid && cfg_ready;
  // cfg_ready is low exactly while a divisor waits for the next period wrap.
  assign cfg_ready     = !r_pend;
  assign w_xfer        = cfg_valid && cfg_ready;
  assign w_cfg_clamped = (cfg_divisor < MIN_DIVISOR) ? MIN_DIVISOR : cfg_divisor;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_active_div <= DEFAULT_DIVISOR;
      r_pend_div   <= DEFAULT_DIVISOR;
      r_pend       <= 1'b0;
    end else if (!w_en) begin
      // A value that slipped into pending on the final drain wrap lands here.
      if (r_pend) begin
        r_active_div <= r_pend_div;
        r_pend       <= 1'b0;
      end else if (w_xfer) begin
        r_active_div <= w_cfg_clamped;
      end
    end else begin
      if (w_wrap && r_pend) begin
        r_active_div <= r_pend_div;
        r_pend       <= 1'b0;
      end
      if (w_xfer) begin
        r_pend     <= 1'b1;
        r_pend_div <= w_cfg_clamped;
      end
    end
  end

  assign active_div = r_active_div;

  div_period_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clock_in (clock_in),
    .reset    (reset),
    .i_en     (w_en),
    .i_div    (r_active_div),
    .o_wrap   (w_wrap),
    .o_tick   (tick),
    .o_c      (c)
  );

endmodule

// File: tb/tb_clock_divide_ctrl.sv
// Bench for clock_divide_ctrl: directed scenarios with literal expectations,
// then random stimulus checked every cycle against a behavioural model.
module tb_clock_divide_ctrl;

  localparam int W = 28;

  logic          clock_in = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [W-1:0]  cfg_divisor = '0;
  logic          cfg_ready;
  logic          c;
  logic          tick;
  logic          running;
  logic [W-1:0]  active_div;
  clock_divide_pkg::state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  clock_divide_ctrl #(
    .WIDTH           (W),
    .DEFAULT_DIVISOR (28'd10),
    .MIN_DIVISOR     (28'd2)
  ) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_divisor (cfg_divisor),
    .cfg_ready   (cfg_ready),
    .c           (c),
    .tick        (tick),
    .running     (running),
    .active_div  (active_div),
    .dbg_state   (dbg_state)
  );

  always #5 clock_in = ~clock_in;

  // Behavioural model: position within the period, dividing/draining flags,
  // active divisor and an optional queued divisor.
  bit m_dividing = 0;
  bit m_draining = 0;
  int m_pos      = 0;
  bit m_c        = 0;
  bit m_tick     = 0;
  int m_div      = 10;
  bit m_has_q    = 0;
  int m_q_div    = 0;

  always @(posedge clock_in) begin
    bit active, wrap, take;
    int want;
    if (reset) begin
      m_dividing = 0; m_draining = 0; m_pos = 0; m_c = 0; m_tick = 0;
      m_div = 10; m_has_q = 0; m_q_div = 0;
    end else begin
      active = m_dividing || m_draining;
      take   = cfg_valid && !m_has_q;
      want   = (int'(cfg_divisor) < 2) ? 2 : int'(cfg_divisor);
      wrap   = active && (m_pos >= m_div - 1);
      m_c    = active && (m_pos < m_div / 2);
      m_tick = wrap;
      m_pos  = (!active || wrap) ? 0 : m_pos + 1;
      if (!active) begin
        if (m_has_q) begin m_div = m_q_div; m_has_q = 0; end
        else if (take) m_div = want;
      end else begin
        if (wrap && m_has_q) begin m_div = m_q_div; m_has_q = 0; end
        if (take) begin m_has_q = 1; m_q_div = want; end
      end
      if (!active) begin
        if (start && !stop) m_dividing = 1;
      end else if (m_dividing) begin
        if (stop) begin m_dividing = 0; m_draining = 1; end
      end else begin
        if (start && !stop) begin m_draining = 0; m_dividing = 1; end
        else if (wrap) m_draining = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock_in) begin
    check("model_c", 32'(c), 32'(m_c));
    check("model_tick", 32'(tick), 32'(m_tick));
    check("model_running", 32'(running), 32'(m_dividing || m_draining));
    check("model_active_div", 32'(active_div), 32'(m_div));
    check("model_cfg_ready", 32'(cfg_ready), 32'(!m_has_q));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic capture_c(input int n, output logic [31:0] cv, output logic [31:0] tv);
    cv = '0; tv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock_in);
      cv[i] = c;
      tv[i] = tick;
    end
  endtask

  initial begin
    logic [31:0] cv, tv;

    // Reset values
    cyc(3);
    check("rst_c", 32'(c), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_running", 32'(running), 0);
    check("rst_active_div", 32'(active_div), 10);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    reset = 1'b0;

    // Default divisor 10: 5 high / 5 low, tick every 10 cycles
    pulse_start();
    capture_c(20, cv, tv);
    check("div10_c", cv, 32'h0007C1F);
    check("div10_tick", tv, 32'h0080200);
    check("div10_running", 32'(running), 1);

    // Stop at counter 2: drain 8 more cycles, then idle
    cyc(2);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(6);
    check("drain_running", 32'(running), 1);
    check("drain_pre_tick", 32'(tick), 0);
    cyc(1);
    check("drain_wrap_tick", 32'(tick), 1);
    check("drain_idle", 32'(running), 0);
    cyc(1);
    check("drain_c_low", 32'(c), 0);

    // Divisor written directly in idle
    cfg_valid = 1'b1; cfg_divisor = 28'd6;
    check("idle_ready", 32'(cfg_ready), 1);
    cyc(1);
    cfg_valid = 1'b0;
    check("idle_cfg_div", 32'(active_div), 6);
    check("idle_cfg_ready", 32'(cfg_ready), 1);
    pulse_start();
    capture_c(12, cv, tv);
    check("div6_c", cv, 32'h1C7);

    // Offer 4 at counter 3 of a 10 period; second offer held off
    reset = 1'b1; cyc(1); reset = 1'b0;
    pulse_start();
    cyc(3);
    cfg_valid = 1'b1; cfg_divisor = 28'd4;
    cyc(1);
    cfg_divisor = 28'd9;
    check("pend_ready_low", 32'(cfg_ready), 0);
    check("pend_div_kept", 32'(active_div), 10);
    cyc(3);
    cfg_valid = 1'b0;
    check("pend_second_held", 32'(active_div), 10);
    check("pend_still_busy", 32'(cfg_ready), 0);
    cyc(2);
    check("pend_no_early_tick", 32'(tick), 0);
    cyc(1);
    check("pend_applied", 32'(active_div), 4);
    check("pend_wrap_tick", 32'(tick), 1);
    check("pend_ready_back", 32'(cfg_ready), 1);
    capture_c(8, cv, tv);
    check("div4_c", cv, 32'h33);

    // start and stop together in RUN -> drain
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    check("ss_drain_running", 32'(running), 1);
    cyc(2);
    check("ss_still_running", 32'(running), 1);
    cyc(1);
    check("ss_idle", 32'(running), 0);

    // Clamping of 0 and 1, then odd divisor 7
    cfg_valid = 1'b1; cfg_divisor = 28'd0; cyc(1);
    check("clamp0", 32'(active_div), 2);
    cfg_divisor = 28'd1; cyc(1);
    check("clamp1", 32'(active_div), 2);
    cfg_valid = 1'b0;
    pulse_start();
    capture_c(6, cv, tv);
    check("div2_c", cv, 32'h15);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(4);
    check("div2_stopped", 32'(running), 0);
    cfg_valid = 1'b1; cfg_divisor = 28'd7; cyc(1); cfg_valid = 1'b0;
    check("div7_set", 32'(active_div), 7);
    pulse_start();
    capture_c(14, cv, tv);
    check("div7_c", cv, 32'h0387);

    // Reset mid-period with a pending divisor
    reset = 1'b1; cyc(1); reset = 1'b0;
    pulse_start();
    cyc(3);
    cfg_valid = 1'b1; cfg_divisor = 28'd5; cyc(1); cfg_valid = 1'b0;
    check("mid_pending", 32'(cfg_ready), 0);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("mid_rst_c", 32'(c), 0);
    check("mid_rst_tick", 32'(tick), 0);
    check("mid_rst_running", 32'(running), 0);
    check("mid_rst_div", 32'(active_div), 10);
    check("mid_rst_ready", 32'(cfg_ready), 1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 19) == 0);
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_divisor = W'($urandom_range(0, 12));
      cyc(1);
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
